spi_slave_mcp: RTL and testbench

SPI mode-0 responder (slave). It is the far end of the link driven by the team's SPI master block. It oversamples sclk/cs/mosi in the system clock domain, deserializes MSB-first bytes to a parallel valid-pulse interface, and serializes a host-loaded byte back on miso. It is used as an on-chip device model and as a loopback target for master bring-up.

---
 rtl/spi_slave_mcp.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave_mcp.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mcp.sv
// SPI mode-0 responder: oversamples sclk/cs/mosi in the clk domain, deserializes MSB-first words
// and serializes a host-loaded word on miso. Optional macro: SPI_SLAVE_ECHO_EN (echo last rx word).
module spi_slave_mcp #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_BYTE   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int                CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall;

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_full_q, tx_full_d;
    logic              reload_q, reload_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              word_load;
    logic [DATA_W-1:0] next_word;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign cs_fall   = cs_prev_q & ~cs_s;

    // History flops reset to 0, so a cs held low through reset never looks like a frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

`ifdef SPI_SLAVE_ECHO_EN
    logic echo_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_valid_q <= 1'b0;
        end else if (rx_valid_d) begin
            echo_valid_q <= 1'b1;
        end
    end

    assign next_word = tx_full_q    ? tx_buf_q  :
                       echo_valid_q ? rx_data_q : IDLE_BYTE;
`else
    assign next_word = tx_full_q ? tx_buf_q : IDLE_BYTE;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        reload_d    = reload_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        word_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    word_load = 1'b1;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                end
            end
            ACTIVE: begin
                // cs release outranks any sclk edge seen in the same cycle.
                if (cs_s) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    reload_d    = 1'b0;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == LAST) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = {rx_shift_q[DATA_W-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                        reload_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (reload_q) begin
                        word_load = 1'b1;
                        reload_d  = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (word_load) begin
            tx_shift_d = next_word;
        end
        // A buffer-to-shifter transfer only happens while full, so a same-cycle load is refused.
        if (word_load && tx_full_q) begin
            tx_full_d = 1'b0;
        end else if (tx_load && !tx_full_q) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            reload_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            reload_q    <= reload_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign busy      = (state_q == ACTIVE);
    assign miso      = busy & tx_shift_q[DATA_W-1];
    assign tx_ready  = ~tx_full_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_mcp.sv
// Self-checking bench for spi_slave_mcp: acts as a mode-0 master with a 16-clk sclk period,
// scoreboards received words and miso words through expected queues.
module tb_spi_slave_mcp;

  localparam int W    = 8;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk;
  logic         cs;
  logic         mosi;
  logic         miso;
  logic [W-1:0] tx_data;
  logic         tx_load;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_miso_q[$];
  logic [W-1:0] got_rx_q[$];
  int           rd_idx = 0;
  int           frame_err_cnt = 0;
  int           overlap_cnt = 0;

  spi_slave_mcp #(.DATA_W(W), .SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // output monitor: records every rx_valid word and counts frame errors
  always @(negedge clk) begin
    if (rx_valid) got_rx_q.push_back(rx_data);
    if (frame_err) frame_err_cnt++;
    if (rx_valid && frame_err) overlap_cnt++;
  end

  // driver tasks
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [W-1:0] d);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic spi_bits(input logic [W-1:0] w, input int n, output logic [W-1:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      mosi = w[W-1-i];
      idle_cycles(HALF);
      got  = {got[W-2:0], miso};
      sclk = 1'b1;
      idle_cycles(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_end();
    idle_cycles(4);
    cs = 1'b1;
    idle_cycles(10);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; tx_data = '0; tx_load = 1'b0;
    idle_cycles(4);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({miso, tx_ready, busy, rx_valid, frame_err} !== 5'b01000 || rx_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d miso/rdy/busy/rxv/ferr=%b rx_data=%h want 01000/00", i,
                 {miso, tx_ready, busy, rx_valid, frame_err}, rx_data);
      end
    end
  endtask

  task automatic test_single_word();
    logic [W-1:0] got, e, a;
    logic [2:0]   rdy_seen, busy_seen;
    int           fe0;
    fe0 = frame_err_cnt;
    load_tx(8'hA5);
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL tx_ready_after_load got=%b want=0", tx_ready);
    end
    exp_miso_q.push_back(8'hA5);
    exp_q.push_back(8'h32);
    cs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rdy_seen[i]  = tx_ready;
      busy_seen[i] = busy;
    end
    checks++;
    if (rdy_seen !== 3'b100 || busy_seen !== 3'b100) begin
      errors++;
      $display("FAIL cs_fall_timing tx_ready=%b busy=%b (cycle2..0) want 100/100", rdy_seen, busy_seen);
    end
    spi_bits(8'h32, 8, got);
    e = exp_miso_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL single_miso got=%h want=%h", got, e); end
    cs_end();
    checks++;
    if (got_rx_q.size() - rd_idx != exp_q.size()) begin
      errors++; $display("FAIL single_rx_count got=%0d want=%0d", got_rx_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < got_rx_q.size()) begin
      e = exp_q.pop_front(); a = got_rx_q[rd_idx]; rd_idx++;
      checks++;
      if (a !== e) begin errors++; $display("FAIL single_rx_data got=%h want=%h", a, e); end
    end
    exp_q.delete(); rd_idx = got_rx_q.size();
    checks++;
    if (frame_err_cnt != fe0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_clean_exit ferr_pulses=%0d busy=%b want 0/0", frame_err_cnt - fe0, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got, e, a;
    load_tx(8'h11);
    load_tx(8'h22);
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_hold got=%b want=0", tx_ready); end
    exp_miso_q.push_back(8'h11);
    exp_miso_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    cs = 1'b0;
    spi_bits(8'h3C, 8, got);
    e = exp_miso_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL b2b_miso_w0 got=%h want=%h", got, e); end
    spi_bits(8'hC3, 8, got);
    e = exp_miso_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL b2b_miso_w1 got=%h want=%h", got, e); end
    cs_end();
    checks++;
    if (got_rx_q.size() - rd_idx != exp_q.size()) begin
      errors++; $display("FAIL b2b_rx_count got=%0d want=%0d", got_rx_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < got_rx_q.size()) begin
      e = exp_q.pop_front(); a = got_rx_q[rd_idx]; rd_idx++;
      checks++;
      if (a !== e) begin errors++; $display("FAIL b2b_rx_data got=%h want=%h", a, e); end
    end
    exp_q.delete(); rd_idx = got_rx_q.size();
  endtask

  task automatic test_frame_err();
    logic [W-1:0] got, e, a;
    int           fe0;
    fe0 = frame_err_cnt;
    cs = 1'b0;
    spi_bits(8'hB6, 5, got);
    checks++;
    if (got !== 8'h1F) begin errors++; $display("FAIL partial_miso got=%h want=1f", got); end
    cs_end();
    checks++;
    if (frame_err_cnt - fe0 != 1 || got_rx_q.size() != rd_idx) begin
      errors++;
      $display("FAIL partial_err ferr_pulses=%0d rx_pulses=%0d want 1/0", frame_err_cnt - fe0,
               got_rx_q.size() - rd_idx);
    end
    exp_miso_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    cs = 1'b0;
    spi_bits(8'h81, 8, got);
    e = exp_miso_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL after_err_miso got=%h want=%h", got, e); end
    cs_end();
    checks++;
    if (got_rx_q.size() - rd_idx != exp_q.size() || frame_err_cnt - fe0 != 1) begin
      errors++;
      $display("FAIL after_err_count rx=%0d ferr=%0d want %0d/1", got_rx_q.size() - rd_idx,
               frame_err_cnt - fe0, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < got_rx_q.size()) begin
      e = exp_q.pop_front(); a = got_rx_q[rd_idx]; rd_idx++;
      checks++;
      if (a !== e) begin errors++; $display("FAIL after_err_rx_data got=%h want=%h", a, e); end
    end
    exp_q.delete(); rd_idx = got_rx_q.size();
  endtask

  task automatic test_mid_frame_reset();
    logic [W-1:0] got, e, a;
    int           fe0;
    load_tx(8'h99);
    cs = 1'b0;
    spi_bits(8'hE0, 3, got);
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    fe0 = frame_err_cnt;
    @(negedge clk);
    checks++;
    if ({miso, tx_ready, busy, rx_valid, frame_err} !== 5'b01000 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_frame miso/rdy/busy/rxv/ferr=%b rx_data=%h want 01000/00",
               {miso, tx_ready, busy, rx_valid, frame_err}, rx_data);
    end
    spi_bits(8'hFF, 5, got);
    idle_cycles(6);
    checks++;
    if (busy !== 1'b0 || got_rx_q.size() != rd_idx || frame_err_cnt != fe0 || miso !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_join busy=%b rx_pulses=%0d ferr=%0d miso=%b want 0/0/0/0", busy,
               got_rx_q.size() - rd_idx, frame_err_cnt - fe0, miso);
    end
    cs = 1'b1;
    idle_cycles(10);
    exp_miso_q.push_back(8'hFF);
    exp_q.push_back(8'h7E);
    cs = 1'b0;
    spi_bits(8'h7E, 8, got);
    e = exp_miso_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL rst_then_miso got=%h want=%h", got, e); end
    cs_end();
    checks++;
    if (got_rx_q.size() - rd_idx != exp_q.size()) begin
      errors++; $display("FAIL rst_then_rx_count got=%0d want=%0d", got_rx_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < got_rx_q.size()) begin
      e = exp_q.pop_front(); a = got_rx_q[rd_idx]; rd_idx++;
      checks++;
      if (a !== e) begin errors++; $display("FAIL rst_then_rx_data got=%h want=%h", a, e); end
    end
    exp_q.delete(); rd_idx = got_rx_q.size();
  endtask

  task automatic test_idle_word();
    logic [W-1:0] got, e, a;
    logic [W-1:0] w1;
    w1 = 8'($urandom_range(0, 255));
`ifdef SPI_SLAVE_ECHO_EN
    exp_miso_q.push_back(8'h7E);
    exp_miso_q.push_back(8'h5A);
`else
    exp_miso_q.push_back(8'hFF);
    exp_miso_q.push_back(8'hFF);
`endif
    exp_q.push_back(8'h5A);
    exp_q.push_back(w1);
    cs = 1'b0;
    spi_bits(8'h5A, 8, got);
    e = exp_miso_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL idle_miso_w0 got=%h want=%h", got, e); end
    spi_bits(w1, 8, got);
    e = exp_miso_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL idle_miso_w1 got=%h want=%h", got, e); end
    cs_end();
    checks++;
    if (got_rx_q.size() - rd_idx != exp_q.size()) begin
      errors++; $display("FAIL idle_rx_count got=%0d want=%0d", got_rx_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < got_rx_q.size()) begin
      e = exp_q.pop_front(); a = got_rx_q[rd_idx]; rd_idx++;
      checks++;
      if (a !== e) begin errors++; $display("FAIL idle_rx_data got=%h want=%h", a, e); end
    end
    exp_q.delete(); rd_idx = got_rx_q.size();
    checks++;
    if (overlap_cnt != 0) begin
      errors++; $display("FAIL rxv_ferr_overlap got=%0d want=0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_frame_err();
    test_mid_frame_reset();
    test_idle_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
